fma_wb_queue: RTL and testbench
===============================

Name: fma_wb_queue

Overview:
- Sits directly downstream of the FMA unit and upstream of the shared FP writeback ports.
- FMA lanes retire results at different latencies: FMUL takes 3 cycles, FADD 2, fused ops 6. This lets mul and add results of one lane collide, and lets lanes outpace the writeback ports.
- The block buffers every lane result in one age-agnostic circular queue, drops redirect-flushed results, and drains to WB_PORTS writeback ports under a valid/ready handshake.
- It also drives a stall to FMA issue so that in-flight results always have room.

Parameters:
- FMA_SIZE, 2, number of FMA result lanes (2 results per lane per cycle max: mul + add).
- WB_PORTS, 1, number of FP writeback ports drained per cycle.
- DEPTH, 16, queue entries (power of two).
- STALL_THRESH, 12, issue_stall asserts when free entries < STALL_THRESH (covers 6-cycle in-flight window x FMA_SIZE).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_en  in  2*FMA_SIZE  result valid; slot 2i = lane i mul, 2i+1 = lane i add.
- in_rd  in  2*FMA_SIZE x PREG_WIDTH  destination preg.
- in_robIdx  in  2*FMA_SIZE x RobIdx  ROB index {dir, idx}.
- in_res  in  2*FMA_SIZE x XLEN  result data.
- in_exccode  in  2*FMA_SIZE x FFlags  exception flags.
- redirect_en  in  1  backend redirect this cycle.
- redirect_robIdx  in  RobIdx  redirecting instruction; strictly younger results are killed.
- wb_valid  out  WB_PORTS  writeback valid.
- wb_ready  in  WB_PORTS  port accepts.
- wb_rd / wb_robIdx / wb_res / wb_exccode  out  WB_PORTS x field  entry payload.
- issue_stall  out  1  block new FMA issue.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset values: head = tail = 0, all entry valid bits 0, count = 0, wb_valid = 0, issue_stall = 0, overflow = 0. Payload registers are not reset.
- Age compare: older(a,b) = (a.dir==b.dir) ? a.idx<b.idx : a.idx>b.idx. An entry is killed when redirect_en && older(redirect_robIdx, entry.robIdx).
- Enqueue:
  - Surviving in_en slots are written in ascending slot order at tail, tail+1, ... (mod DEPTH).
  - Tail advances by the number written.
  - Slots killed by a same-cycle redirect are not written.
- Queue state: each slot holds a valid bit. Killed entries already in the queue have valid cleared in the redirect cycle; they still occupy the slot until popped.
- Dequeue/output:
  - wb_valid[p] and payload are combinational from slot head+p, for the first WB_PORTS slots that are occupied (head+p < tail) and valid.
  - Invalid occupied slots at head are skipped and popped freely; at most WB_PORTS slots are examined per cycle.
  - Valid slots pop only on wb_valid && wb_ready, in order. If port p is not accepted, ports > p are not popped that cycle.
  - An entry being killed this cycle must not present wb_valid.
- Latency: minimum 1 cycle from in_en to wb_valid, with no bypass.
- Count: count = tail - head (DEPTH+1 states). free = DEPTH - count. issue_stall is registered: it asserts in the cycle after free < STALL_THRESH.
- Full: if surviving enqueues exceed free, the excess slots (highest index) are dropped and overflow sets sticky until rst. The bench treats this as an error.
- Simultaneous enqueue, dequeue and redirect: compute dequeue and kill on current state, then apply enqueue. A slot popped this cycle is reusable next cycle, not the same cycle.
- Reset mid-operation: all entries are discarded in the reset cycle, with no wb_valid after reset asserts.
- Wrap: head and tail carry an extra wrap bit for the full/empty distinction.

Decomposition:
- Shared backend package: RobIdx typedef, the FMA writeback entry struct {rd, robIdx, res, exccode}, and an older() function reused by other flush logic.
- One natural sub-module: fma_wb_select, the combinational head scan producing per-port valid, pop count and skip count.

Test Plan:
- Single lane-0 add result, rd=5, res=32'h3F800000, wb_ready=1 → wb_valid on the next cycle with rd=5 and the same res; queue empty after.
- Lane 0 mul and add both valid in the same cycle (robIdx 3 and 4), WB_PORTS=1 → robIdx 3 written back, then robIdx 4 the following cycle; no loss.
- wb_ready held 0 while 12 results arrive → issue_stall asserts in the cycle after free drops below 12. Release ready → drains in enqueue order and issue_stall deasserts.
- Queue holds robIdx {0,5},{0,9},{0,2}; redirect_robIdx={0,4} → only {0,2} is written back; the others never show wb_valid; count returns to 0.
- Wrap-bit compare: redirect {1,1} with entry {0,14} → entry kept. Entry {1,3} → killed.
- 17 results with wb_ready=0 → overflow=1, the 17th is dropped, the first 16 drain intact; rst mid-drain → wb_valid=0, count=0, overflow=0 the next cycle.

Source files
------------

// File: rtl/fma_wb_queue_pkg.sv
// Shared FP backend types: ROB index, FMA writeback entry and the ROB age compare
// used by every flush path.
package fma_wb_queue_pkg;

    localparam int PREG_WIDTH = 7;
    localparam int XLEN       = 32;
    localparam int FFLAGS_W   = 5;
    localparam int ROB_IDX_W  = 4;

    typedef struct packed {
        logic                 dir;
        logic [ROB_IDX_W-1:0] idx;
    } rob_idx_t;

    typedef struct packed {
        logic [PREG_WIDTH-1:0] rd;
        rob_idx_t              robIdx;
        logic [XLEN-1:0]       res;
        logic [FFLAGS_W-1:0]   exccode;
    } fma_wb_entry_t;

    // True when a is older than b; dir flips each time the ROB pointer wraps.
    function automatic logic older(input rob_idx_t a, input rob_idx_t b);
        return (a.dir == b.dir) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/fma_wb_queue_if.sv
// FMA result bus in, FP writeback ports out. master = producer/consumer side,
// slave = the writeback queue.
interface fma_wb_queue_if #(
    parameter int FMA_SIZE = 2,
    parameter int WB_PORTS = 1
);
    import fma_wb_queue_pkg::*;

    localparam int N_IN = 2 * FMA_SIZE;

    logic [N_IN-1:0]                 in_en;
    logic [N_IN-1:0][PREG_WIDTH-1:0] in_rd;
    rob_idx_t [N_IN-1:0]             in_robIdx;
    logic [N_IN-1:0][XLEN-1:0]       in_res;
    logic [N_IN-1:0][FFLAGS_W-1:0]   in_exccode;

    logic [WB_PORTS-1:0]                 wb_valid;
    logic [WB_PORTS-1:0]                 wb_ready;
    logic [WB_PORTS-1:0][PREG_WIDTH-1:0] wb_rd;
    rob_idx_t [WB_PORTS-1:0]             wb_robIdx;
    logic [WB_PORTS-1:0][XLEN-1:0]       wb_res;
    logic [WB_PORTS-1:0][FFLAGS_W-1:0]   wb_exccode;

    modport master (
        output in_en, in_rd, in_robIdx, in_res, in_exccode, wb_ready,
        input  wb_valid, wb_rd, wb_robIdx, wb_res, wb_exccode
    );

    modport slave (
        input  in_en, in_rd, in_robIdx, in_res, in_exccode, wb_ready,
        output wb_valid, wb_rd, wb_robIdx, wb_res, wb_exccode
    );

endinterface

// File: rtl/fma_wb_select.sv
// Head scan of the writeback queue: which ports present a result, how many live
// entries were accepted and how many dead entries were skipped this cycle.
module fma_wb_select #(
    parameter int WB_PORTS = 1,
    parameter int CNT_W    = 5
) (
    input  logic [CNT_W-1:0]    count,
    input  logic [WB_PORTS-1:0] slot_live,
    input  logic [WB_PORTS-1:0] wb_ready,
    output logic [WB_PORTS-1:0] wb_valid,
    output logic [CNT_W-1:0]    acc_cnt,
    output logic [CNT_W-1:0]    skip_cnt
);

    logic blocked;

    // A refused port hides all later ports, so nothing is offered that cannot pop.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        wb_valid = '0;
        acc_cnt  = '0;
        skip_cnt = '0;
        blocked  = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (!blocked && (CNT_W'(p) < count)) begin
                if (slot_live[p]) begin
                    wb_valid[p] = 1'b1;
                    if (wb_ready[p]) acc_cnt = acc_cnt + 1'b1;
                    else             blocked = 1'b1;
                end else begin
                    skip_cnt = skip_cnt + 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fma_wb_queue.sv
// Circular writeback queue between the FMA lanes and the shared FP writeback ports,
// with redirect kill, issue back-pressure and a sticky overflow flag.
module fma_wb_queue
    import fma_wb_queue_pkg::*;
#(
    parameter int FMA_SIZE     = 2,
    parameter int WB_PORTS     = 1,
    parameter int DEPTH        = 16,
    parameter int STALL_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fma_wb_queue_if.slave        bus,
    input  logic                 redirect_en,
    input  rob_idx_t             redirect_robIdx,
    output logic                 issue_stall,
    output logic                 overflow
);

    localparam int N_IN = 2 * FMA_SIZE;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;

    logic [PW-1:0]             head, tail, count, free;
    logic [DEPTH-1:0]          vld, vld_nxt, kill_q;
    fma_wb_entry_t             mem [DEPTH];
    logic [WB_PORTS-1:0]       slot_live;
    logic [PW-1:0]             acc_cnt, skip_cnt, pop_cnt, n_wr;
    logic [N_IN-1:0]           wr_en;
    logic [N_IN-1:0][AW-1:0]   wr_idx;
    logic                      drop;

    assign count   = tail - head;
    assign free    = PW'(DEPTH) - count;
    assign pop_cnt = acc_cnt + skip_cnt;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            kill_q[i] = redirect_en && older(redirect_robIdx, mem[i].robIdx);
    end

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
        logic [AW-1:0] slot;
        assign slot                 = head[AW-1:0] + AW'(p);
        assign slot_live[p]         = !rst && vld[slot] && !kill_q[slot];
        assign bus.wb_rd[p]         = mem[slot].rd;
        assign bus.wb_robIdx[p]     = mem[slot].robIdx;
        assign bus.wb_res[p]        = mem[slot].res;
        assign bus.wb_exccode[p]    = mem[slot].exccode;
    end

    fma_wb_select #(
        .WB_PORTS (WB_PORTS),
        .CNT_W    (PW)
    ) u_select (
        .count     (count),
        .slot_live (slot_live),
        .wb_ready  (bus.wb_ready),
        .wb_valid  (bus.wb_valid),
        .acc_cnt   (acc_cnt),
        .skip_cnt  (skip_cnt)
    );

    // Capacity is judged on pre-pop state: a slot freed this cycle is reused next cycle.
    always_comb begin
        wr_en  = '0;
        wr_idx = '0;
        n_wr   = '0;
        drop   = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.in_en[i] && !(redirect_en && older(redirect_robIdx, bus.in_robIdx[i]))) begin
                if (n_wr < free) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = tail[AW-1:0] + n_wr[AW-1:0];
                    n_wr      = n_wr + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        vld_nxt = vld & ~kill_q;
        for (int p = 0; p < WB_PORTS; p++)
            if (PW'(p) < pop_cnt) vld_nxt[head[AW-1:0] + AW'(p)] = 1'b0;
        for (int i = 0; i < N_IN; i++)
            if (wr_en[i]) vld_nxt[wr_idx[i]] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            vld         <= '0;
            issue_stall <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            head        <= head + pop_cnt;
            tail        <= tail + n_wr;
            vld         <= vld_nxt;
            issue_stall <= (free < PW'(STALL_THRESH));
            if (drop) overflow <= 1'b1;
        end
    end

    // NOTE: the payload array is deliberately not reset; the valid bits alone give a slot meaning.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++)
            if (wr_en[i])
                mem[wr_idx[i]] <= fma_wb_entry_t'{bus.in_rd[i], bus.in_robIdx[i],
                                                  bus.in_res[i], bus.in_exccode[i]};
    end

endmodule

// File: tb/tb_fma_wb_queue.sv
// Directed bench for fma_wb_queue: expected writebacks are queued at enqueue time
// and compared, in order, whenever a result is accepted.
module tb_fma_wb_queue;
    import fma_wb_queue_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     redirect_en;
    rob_idx_t redirect_robIdx;
    logic     issue_stall;
    logic     overflow;

    int vectors     = 0;
    int miscompares = 0;
    fma_wb_entry_t sb [$];

    fma_wb_queue_if #(.FMA_SIZE(2), .WB_PORTS(1)) bus ();

    fma_wb_queue #(
        .FMA_SIZE     (2),
        .WB_PORTS     (1),
        .DEPTH        (16),
        .STALL_THRESH (12)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .redirect_en     (redirect_en),
        .redirect_robIdx (redirect_robIdx),
        .issue_stall     (issue_stall),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int s, input logic dir, input logic [ROB_IDX_W-1:0] idx,
                       input logic [PREG_WIDTH-1:0] rd, input logic [XLEN-1:0] res,
                       input bit keep);
        fma_wb_entry_t e;
        e.rd         = rd;
        e.robIdx.dir = dir;
        e.robIdx.idx = idx;
        e.res        = res;
        e.exccode    = FFLAGS_W'($urandom);
        bus.in_en[s]      = 1'b1;
        bus.in_rd[s]      = e.rd;
        bus.in_robIdx[s]  = e.robIdx;
        bus.in_res[s]     = e.res;
        bus.in_exccode[s] = e.exccode;
        if (keep) sb.push_back(e);
    endtask

    // Compare an accepted writeback against the oldest expected result.
    task automatic observe();
        fma_wb_entry_t o;
        if (bus.wb_valid[0] === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'(bus.wb_robIdx[0]), 64'hFFFF);
            end else if (bus.wb_ready[0]) begin
                o = fma_wb_entry_t'{bus.wb_rd[0], bus.wb_robIdx[0], bus.wb_res[0], bus.wb_exccode[0]};
                chk("wb_entry", 64'(o), 64'(sb.pop_front()));
            end
        end
    endtask

    task automatic cycle();
        #1;
        observe();
        @(posedge clk);
        #1;
        bus.in_en   = '0;
        redirect_en = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        redirect_en     = 1'b0;
        redirect_robIdx = '0;
        bus.in_en       = '0;
        bus.in_rd       = '0;
        bus.in_robIdx   = '0;
        bus.in_res      = '0;
        bus.in_exccode  = '0;
        bus.wb_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_stall",    64'(issue_stall),  64'd0);
        chk("rst_overflow", 64'(overflow),     64'd0);
        chk("rst_count",    64'(dut.count),    64'd0);

        // Single lane-0 add result, one cycle to writeback.
        put(1, 1'b0, 4'd1, 7'd5, 32'h3F80_0000, 1'b1);
        #1;
        chk("t1_no_bypass", 64'(bus.wb_valid), 64'd0);
        cycle();
        chk("t1_valid", 64'(bus.wb_valid), 64'd1);
        chk("t1_rd",    64'(bus.wb_rd[0]), 64'd5);
        chk("t1_res",   64'(bus.wb_res[0]), 64'h3F80_0000);
        cycle();
        chk("t1_empty", 64'(dut.count), 64'd0);

        // Mul and add of lane 0 collide; both written back in order.
        put(0, 1'b0, 4'd3, PREG_WIDTH'($urandom), $urandom, 1'b1);
        put(1, 1'b0, 4'd4, PREG_WIDTH'($urandom), $urandom, 1'b1);
        cycle();
        drain("t2", 6);
        chk("t2_empty", 64'(dut.count), 64'd0);

        // Back-pressure: 12 results with the ports stalled, then release.
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            put(0, 1'b0, 4'(2 * k),     PREG_WIDTH'($urandom), $urandom, 1'b1);
            put(2, 1'b0, 4'(2 * k + 1), PREG_WIDTH'($urandom), $urandom, 1'b1);
            cycle();
            chk($sformatf("t3_fill_stall%0d", k), 64'(issue_stall), 64'(k >= 3));
        end
        chk("t3_count", 64'(dut.count), 64'd12);
        bus.wb_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cycle();
            chk($sformatf("t3_drain_stall%0d", j), 64'(issue_stall), 64'(j < 8));
        end
        chk("t3_drained", 64'(sb.size()), 64'd0);
        chk("t3_empty",   64'(dut.count), 64'd0);
        chk("t3_no_ovf",  64'(overflow),  64'd0);

        // Redirect kills the two younger queued results.
        bus.wb_ready = 1'b0;
        put(0, 1'b0, 4'd5, PREG_WIDTH'($urandom), $urandom, 1'b0);
        put(1, 1'b0, 4'd9, PREG_WIDTH'($urandom), $urandom, 1'b0);
        put(2, 1'b0, 4'd2, PREG_WIDTH'($urandom), $urandom, 1'b1);
        cycle();
        bus.wb_ready    = 1'b1;
        redirect_en     = 1'b1;
        redirect_robIdx = '{dir: 1'b0, idx: 4'd4};
        #1;
        chk("t4_kill_novalid", 64'(bus.wb_valid), 64'd0);
        cycle();
        drain("t4", 8);
        chk("t4_empty", 64'(dut.count), 64'd0);

        // Wrap-bit compare, queued entries then same-cycle enqueue.
        bus.wb_ready = 1'b0;
        put(0, 1'b0, 4'd14, PREG_WIDTH'($urandom), $urandom, 1'b1);
        put(1, 1'b1, 4'd3,  PREG_WIDTH'($urandom), $urandom, 1'b0);
        cycle();
        bus.wb_ready    = 1'b1;
        redirect_en     = 1'b1;
        redirect_robIdx = '{dir: 1'b1, idx: 4'd1};
        #1;
        chk("t5_keep_valid", 64'(bus.wb_valid), 64'd1);
        cycle();
        redirect_en     = 1'b1;
        redirect_robIdx = '{dir: 1'b1, idx: 4'd1};
        put(0, 1'b1, 4'd3,  PREG_WIDTH'($urandom), $urandom, 1'b0);
        put(1, 1'b0, 4'd14, PREG_WIDTH'($urandom), $urandom, 1'b1);
        cycle();
        drain("t5", 8);
        chk("t5_empty", 64'(dut.count), 64'd0);

        // Overflow: 17 results into 16 entries, then reset mid-drain.
        bus.wb_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 4; s++)
                put(s, 1'b0, 4'(4 * c + s), PREG_WIDTH'($urandom), $urandom, 1'b1);
            cycle();
        end
        chk("t6_full", 64'(dut.count), 64'd16);
        put(0, 1'b1, 4'd0, PREG_WIDTH'($urandom), $urandom, 1'b0);
        #1;
        chk("t6_ovf_pre", 64'(overflow), 64'd0);
        cycle();
        chk("t6_ovf_set", 64'(overflow),  64'd1);
        chk("t6_count",   64'(dut.count), 64'd16);
        bus.wb_ready = 1'b1;
        repeat (5) cycle();
        chk("t6_partial", 64'(sb.size()), 64'd11);
        rst = 1'b1;
        #1;
        chk("t6_rst_novalid", 64'(bus.wb_valid), 64'd0);
        cycle();
        rst = 1'b0;
        #1;
        chk("t6_post_valid", 64'(bus.wb_valid), 64'd0);
        chk("t6_post_count", 64'(dut.count),    64'd0);
        chk("t6_post_ovf",   64'(overflow),     64'd0);
        chk("t6_post_stall", 64'(issue_stall),  64'd0);
        sb.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
